// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART TX arbiter and its round-robin picker:
//   - arb_state_t      : arbiter state encoding (IDLE, OWN)
//   - DEFAULT_TIMEOUT  : default idle-cycle budget for a granted requester
//   - idx_width(n)     : width of an index able to address n requesters
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Never returns 0, so a 2-requester arbiter still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Starting at position ptr and wrapping
// modulo N, it selects the first set bit of req.
// Ports:
//   req  [N-1:0]  input   request vector
//   ptr  [IW-1:0] input   highest-priority position (must be < N)
//   gnt  [N-1:0]  output  one-hot winner, 0 when req == 0
//   idx  [IW-1:0] output  index of the winner, 0 when req == 0
//   any           output  high when some request is set
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // Walk the N positions in priority order starting at ptr; the first
    // requester found wins, and later hits are ignored.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between N byte-stream requesters using
// round-robin fairness. A requester keeps the grant for a whole packet,
// which ends with the byte that has req_last set. Bytes from different
// requesters therefore never interleave. The owner's data path to the
// UART is purely combinational.
// Optional feature: when the macro UART_ARB_TIMEOUT_EN is defined, the
// arbiter forcibly releases an owner that stays idle mid-packet for
// TIMEOUT cycles, and pulses timeout_evt.
// Ports:
//   clock                    system clock, rising edge
//   reset                    synchronous, active-low reset
//   req_valid  [N-1:0]       per-requester byte valid
//   req_data   [N*W-1:0]     per-requester byte; requester i at [i*W +: W]
//   req_last   [N-1:0]       per-requester last byte of packet
//   req_ready  [N-1:0]       per-requester accept (at most one bit set)
//   tx_valid                 byte valid to the UART TX
//   tx_data    [W-1:0]       byte to the UART TX
//   tx_ready                 UART TX can accept a byte
//   gnt        [N-1:0]       one-hot current owner, 0 when idle
//   busy                     a packet is currently granted
//   timeout_evt              one-cycle pulse on a forced release
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic           tx_valid,
    output logic [W-1:0]   tx_data,
    input  logic           tx_ready,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           timeout_evt
);

    localparam int IW = idx_width(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("uart_tx_arbiter: N must be in 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_t    state;
    arb_state_t    state_next;
    logic [IW-1:0] owner_idx;
    logic [IW-1:0] ptr;
    logic [N-1:0]  gnt_q;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    logic          own_valid;
    logic          own_last;
    logic [W-1:0]  own_data;
    logic          release_pkt;
    logic          release_to;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Select the current owner's lane.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_idx == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*W +: W];
            end
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state == OWN);
    assign tx_valid    = (state == OWN) && own_valid;
    assign tx_data     = own_data;
    // gnt_q is the owner's one-hot, so it doubles as the ready steering mask.
    assign req_ready   = ((state == OWN) && tx_ready) ? gnt_q : '0;
    assign release_pkt = (state == OWN) && own_valid && tx_ready && own_last;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The grant is taken from the sampled request vector.
    // A release always passes through IDLE, which leaves one bubble cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_any) state_next = OWN;
            OWN:  if (release_pkt || release_to) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Owner, grant and priority pointer. The pointer moves past the
    // releasing owner, so that requester has the lowest priority next time.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gnt_q     <= '0;
            owner_idx <= '0;
            ptr       <= '0;
        end else if (state == IDLE && pick_any) begin
            gnt_q     <= pick_gnt;
            owner_idx <= pick_idx;
        end else if (state == OWN && (release_pkt || release_to)) begin
            gnt_q <= '0;
            ptr   <= (owner_idx == IW'(N - 1)) ? '0 : owner_idx + 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] idle_cnt;
    logic          evt_q;

    // Only cycles where the owner has nothing to send count toward the
    // timeout. A tx_ready stall with valid high is back-pressure, not
    // abandonment.
    assign release_to  = (state == OWN) && !own_valid && (idle_cnt == TW'(TIMEOUT - 1));
    assign timeout_evt = evt_q;

    // Idle counter. It starts from zero on every grant because it is held
    // clear while IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idle_cnt <= '0;
            evt_q    <= 1'b0;
        end else begin
            evt_q <= release_to;
            if (state != OWN || own_valid || release_to) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign release_to  = 1'b0;
    assign timeout_evt = 1'b0;
`endif

endmodule
